// File: rtl/column_cursor_encoder.sv
// Column cursor encoder for a seven-column drop game.
// Turns left/right/drop buttons into a one-hot cursor and a drop request
// handshake. It skips full columns while moving and holds the drop request
// until the game logic acknowledges it.
// Optional feature: define COLUMN_CURSOR_DEBOUNCE_EN to add a per-button
// debouncer of DEBOUNCE_CYCLES stable samples.
module column_cursor_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_drop,
  input  logic [6:0] col_full,
  input  logic       drop_ack,
  output logic [6:0] cursor_onehot,
  output logic       drop_valid,
  output logic [6:0] drop_column
);

  typedef enum logic [1:0] {StIdle, StWaitAck, StWaitClear} state_e;

  // Stop elaboration early on a meaningless debounce length.
  if (DEBOUNCE_CYCLES == 0) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be nonzero");
  end

  // Bit 0 = left, bit 1 = right, bit 2 = drop.
  logic [2:0] btn_raw;
  logic [2:0] btn_q;
  logic [2:0] level;
  logic [2:0] prev_q;
  logic [2:0] arm_q;
  logic [2:0] event_q;

  assign btn_raw = {btn_drop, btn_right, btn_left};

  // Input synchronising register.
  always_ff @(posedge clk) begin
    if (reset) btn_q <= 3'b000;
    else       btn_q <= btn_raw;
  end

`ifdef COLUMN_CURSOR_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar i = 0; i < 3; i++) begin : g_debounce
    logic [CntW-1:0] cnt_q;
    logic            lvl_q;

    // Flip the filtered level only after an unbroken run of differing samples.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (btn_q[i] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        lvl_q <= btn_q[i];
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end

    assign level[i] = lvl_q;
  end
`else
  assign level = btn_q;
`endif

  // Registered rising-edge detector. A button only arms once its raw input
  // has been seen low, so a button held through reset stays silent until
  // it is released and pressed again.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 3'b000;
      arm_q   <= 3'b000;
      event_q <= 3'b000;
    end else begin
      prev_q  <= level;
      arm_q   <= arm_q | ~btn_raw;
      event_q <= level & ~prev_q & arm_q;
    end
  end

  logic ev_left, ev_right, ev_drop;
  assign ev_left  = event_q[0];
  assign ev_right = event_q[1];
  assign ev_drop  = event_q[2];

  // Nearest non-full column to the left with wrap; unchanged if none.
  function automatic logic [2:0] step_left(input logic [2:0] cur, input logic [6:0] full);
    logic [2:0] res;
    logic [2:0] idx;
    logic       found;
    res   = cur;
    idx   = cur;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idx = (idx == 3'd0) ? 3'd6 : idx - 3'd1;
      if (!found && !full[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Nearest non-full column to the right with wrap; unchanged if none.
  function automatic logic [2:0] step_right(input logic [2:0] cur, input logic [6:0] full);
    logic [2:0] res;
    logic [2:0] idx;
    logic       found;
    res   = cur;
    idx   = cur;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idx = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
      if (!found && !full[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  state_e     state_q, state_d;
  logic [2:0] cur_q, cur_d;
  logic       valid_q, valid_d;
  logic [6:0] col_q, col_d;

  // Cursor is kept as an index; the one-hot form is always a single bit.
  assign cursor_onehot = 7'(1) << cur_q;
  assign drop_valid    = valid_q;
  assign drop_column   = col_q;

  // State and cursor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cur_q   <= 3'd3;
      valid_q <= 1'b0;
      col_q   <= 7'b0000000;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      col_q   <= col_d;
    end
  end

  // Next-state logic for the drop handshake and cursor movement.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    valid_d = valid_q;
    col_d   = col_q;
    case (state_q)
      StIdle: begin
        // A drop event always wins; any coincident move is discarded.
        if (ev_drop) begin
          if (!col_full[cur_q]) begin
            col_d   = cursor_onehot;
            valid_d = 1'b1;
            state_d = StWaitAck;
          end
        end else if (ev_left && !ev_right) begin
          cur_d = step_left(cur_q, col_full);
        end else if (ev_right && !ev_left) begin
          cur_d = step_right(cur_q, col_full);
        end
      end
      StWaitAck: begin
        if (drop_ack) begin
          valid_d = 1'b0;
          state_d = StWaitClear;
        end
      end
      StWaitClear: begin
        // col_full has had a cycle to reflect the drop.
        if (col_full[cur_q]) cur_d = step_right(cur_q, col_full);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/column_cursor_encoder.md
COLUMN_CURSOR_ENCODER -- requirements
Module: column_cursor_encoder

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, number of consecutive stable samples a button needs before its filtered level changes (used only with COLUMN_CURSOR_DEBOUNCE_EN).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_left  input  1  move-cursor-left button, active-high.
REQ-005 btn_right  input  1  move-cursor-right button, active-high.
REQ-006 btn_drop  input  1  drop-piece button, active-high.
REQ-007 col_full  input  7  per-column full flag from the board (bit i = column i full).
REQ-008 drop_ack  input  1  game logic accepted the pending drop.
REQ-009 cursor_onehot  output  7  one-hot current cursor column (bit 0 = leftmost), same encoding the column decoder consumes.
REQ-010 drop_valid  output  1  drop request pending.
REQ-011 drop_column  output  7  one-hot column of the pending drop; stable while drop_valid is high.

Function
REQ-012 Each button SHALL pass through one input register, then (if enabled) the debouncer, then a rising-edge detector; only a detected rising edge is an event.
REQ-013 Without debounce, a button first sampled high at edge k SHALL produce its effect visible after edge k+2; holding a button SHALL produce exactly one event.
REQ-014 cursor_onehot SHALL always have exactly one bit set.
REQ-015 Left event: cursor SHALL move to the nearest non-full column to the left, wrapping from column 0 to column 6; right event symmetric, wrapping 6 to 0.
REQ-016 If all columns other than the current one are full, a move event SHALL leave the cursor unchanged.
REQ-017 Left and right events in the same cycle SHALL both be ignored.
REQ-018 FSM states: IDLE, WAIT_ACK, WAIT_CLEAR.
REQ-019 IDLE: drop event on a non-full cursor column SHALL load drop_column with cursor_onehot, assert drop_valid, go WAIT_ACK; drop event on a full column SHALL be ignored.
REQ-020 A drop event coincident with a move event SHALL be processed as a drop from the pre-move cursor; the move SHALL be discarded.
REQ-021 WAIT_ACK: drop_valid and drop_column SHALL hold; move and drop events SHALL be ignored; drop_ack high SHALL deassert drop_valid on the next edge and go WAIT_CLEAR.
REQ-022 WAIT_CLEAR: one cycle for col_full to update; then, if the cursor column is now full, cursor SHALL advance right per REQ-015/016; go IDLE.
REQ-023 drop_ack in IDLE or WAIT_CLEAR SHALL be ignored.

Reset
REQ-024 Reset SHALL set cursor_onehot=7'b0001000 (column 3), drop_valid=0, drop_column=0, FSM=IDLE, input/edge registers and debounce counters/levels to 0.
REQ-025 Reset asserted mid-handshake SHALL abandon the pending drop; a button held through reset SHALL not generate an event until released and pressed again.

Configuration
REQ-026 Macro COLUMN_CURSOR_DEBOUNCE_EN defined: each button has a counter; filtered level changes only after DEBOUNCE_CYCLES consecutive samples differing from it; any mismatch-free glitch shorter than that SHALL be rejected; latency per REQ-013 plus DEBOUNCE_CYCLES cycles.
REQ-027 Macro undefined: no debounce logic; filtered level equals the registered input.

Verification
REQ-028 Reset, col_full=0 -> cursor_onehot=7'b0001000, drop_valid=0.
REQ-029 Cursor at 7'b1000000, one right pulse -> 7'b0000001 (wrap); from 7'b0000001, one left pulse -> 7'b1000000.
REQ-030 Cursor 7'b0001000, col_full=7'b0110000, right pulse -> 7'b1000000; col_full=7'b1110111, left pulse -> unchanged 7'b0001000.
REQ-031 Cursor 7'b0000100, drop pulse -> drop_valid=1, drop_column=7'b0000100; further buttons ignored; drop_ack 1 cycle -> drop_valid=0 next edge; col_full then 7'b0000100 -> cursor 7'b0001000.
REQ-032 Drop on full column (col_full=7'b0001000, cursor 7'b0001000) -> drop_valid stays 0; left+right same cycle -> cursor unchanged.
REQ-033 With COLUMN_CURSOR_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 5-cycle right glitch -> no move; 20-cycle press -> one move; reset during WAIT_ACK -> drop_valid=0, cursor 7'b0001000.
